// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the fetch stage (IF) and the memory
// stage (MEM) of a pipeline. Only one access is in flight at a time, and MEM
// always wins when both stages ask for the port in the same cycle.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   if_req, if_addr, if_flush    fetch request; a flush cancels the fetch
//   mem_req, mem_we,
//   mem_addr, mem_wdata          load/store request from the MEM stage
//   if_valid, if_rdata           fetch completion pulse and instruction
//   mem_valid, mem_rdata         data completion pulse, load data (0 on store)
//   stall_if, stall_mem          pipeline hold requests (combinational)
//   m_req, m_we, m_addr,
//   m_wdata                      request to the memory, fields stable while
//                                m_req is high
//   m_ready, m_rdata             one-cycle memory completion and read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,

    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,

    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_rdata,

    output logic            stall_if,
    output logic            stall_mem,

    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic            m_ready,
    input  logic [XLEN-1:0] m_rdata
);

    // state    | meaning
    // ---------+---------------------------------------------------------
    // IDLE     | port free; grant MEM first, else an unflushed fetch
    // BUSY_IF  | fetch in flight, m_req high, waiting for m_ready
    // BUSY_MEM | load/store in flight, m_req high, waiting for m_ready
    // DONE     | one valid pulse for the served requester; never grants
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       served_mem;
    logic       drop;

    logic       grant_mem;
    logic       grant_if;
    logic       fetch_cancel;

    assign grant_mem = (state == IDLE) && mem_req;
    assign grant_if  = (state == IDLE) && !mem_req && if_req && !if_flush;

    // A flush arriving in the same cycle as m_ready must also cancel the
    // fetch, so the live flush input is folded in with the stored flag.
    assign fetch_cancel = drop || if_flush;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_mem) begin
                    state_nxt = BUSY_MEM;
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (m_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured only at the grant edge and then held for
    // the whole access, independent of what the requesters do meanwhile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            served_mem <= 1'b0;
        end else if (grant_mem) begin
            m_we       <= mem_we;
            m_addr     <= mem_addr;
            m_wdata    <= mem_wdata;
            served_mem <= 1'b1;
        end else if (grant_if) begin
            m_we       <= 1'b0;
            m_addr     <= if_addr;
            m_wdata    <= '0;
            served_mem <= 1'b0;
        end
    end

    // Drop flag: remembers that the fetch in flight was redirected away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop <= 1'b0;
        end else if (state == BUSY_IF && if_flush) begin
            drop <= 1'b1;
        end else if (state == DONE) begin
            drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else if (m_ready) begin
            if (state == BUSY_MEM) begin
                mem_rdata <= m_we ? '0 : m_rdata;
            end else if (state == BUSY_IF && !fetch_cancel) begin
                if_rdata <= m_rdata;
            end
        end
    end

    assign m_req     = (state == BUSY_IF) || (state == BUSY_MEM);
    assign mem_valid = (state == DONE) && served_mem;
    assign if_valid  = (state == DONE) && !served_mem && !drop;

    assign stall_mem = mem_req && !mem_valid;
    assign stall_if  = (if_req && !if_valid) || stall_mem;

endmodule
